midi_encode: RTL and testbench

//  Serial MIDI transmitter: takes one note-on/note-off event (channel, note, velocity), frames it as
//  a 3-byte MIDI message and shifts it out at 31250 baud, 8N1, on a single TX wire. Output stage of
//  the MIDI path; drives the MIDI OUT line. Counterpart of the MIDI note receiver.

---
 rtl/midi_pkg.sv | 17 +
 rtl/uart_transmit.sv | 66 ++++++
 rtl/midi_encode.sv | 135 +++++++++++++
 tb/tb_midi_encode.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and the message-level FSM state type used by the MIDI transmitter.
package midi_pkg;

    localparam int         MIDI_BAUD = 31250;
    localparam logic [3:0] NOTE_ON   = 4'h9;
    localparam logic [3:0] NOTE_OFF  = 4'h8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_STATUS,
        SEND_NOTE,
        SEND_VEL,
        DONE
    } midi_tx_state_t;

endpackage

// File: rtl/uart_transmit.sv
// 8N1 serial byte transmitter: start bit, eight data bits LSB first, stop bit,
// each held for INPUT_CLOCK_FREQ/BAUD_RATE clock cycles.
module uart_transmit
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = MIDI_BAUD
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger_in,
    input  logic [7:0] data_byte_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       tx_wire_out
);

    localparam int            BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int            CW         = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shift;

    // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wire_out <= 1'b1;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= 4'd0;
            shift       <= 8'h00;
        end else begin
            done_out <= 1'b0;
            if (!busy_out) begin
                if (trigger_in) begin
                    busy_out    <= 1'b1;
                    tx_wire_out <= 1'b0;
                    shift       <= data_byte_in;
                    baud_cnt    <= '0;
                    bit_idx     <= 4'd0;
                end
            end else if (baud_cnt == LAST_CNT) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    busy_out    <= 1'b0;
                    done_out    <= 1'b1;
                    tx_wire_out <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        tx_wire_out <= 1'b1;
                    end else begin
                        tx_wire_out <= shift[0];
                        shift       <= {1'b0, shift[7:1]};
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_encode.sv
// MIDI note-on/note-off transmitter: captures one event, frames it as status/note/velocity
// bytes (optionally with running status) and shifts them out through uart_transmit.
module midi_encode
    import midi_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ      = 100_000_000,
    parameter int BAUD_RATE             = MIDI_BAUD,
    parameter int RUNNING_STATUS        = 0,
    parameter int STATUS_REFRESH_CYCLES = 30_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       data_valid_in,
    input  logic       status_in,
    input  logic [3:0] channel_in,
    input  logic [7:0] note_in,
    input  logic [7:0] velocity_in,
    output logic       ready_out,
    output logic       msg_done_out,
    output logic       midi_data_out
);

    localparam int            RW          = $clog2(STATUS_REFRESH_CYCLES + 1);
    localparam logic [RW-1:0] REFRESH_MAX = RW'(STATUS_REFRESH_CYCLES);

    midi_tx_state_t state;
    logic [7:0]     status_q;
    logic [7:0]     note_q;
    logic [7:0]     vel_q;
    logic [7:0]     last_status;
    logic           last_valid;
    logic [7:0]     tx_byte;
    logic           tx_trigger;
    logic           tx_busy;
    logic           tx_done;
    logic [RW-1:0]  refresh_cnt;
    logic           accept;
    logic           skip_status;

    assign accept      = data_valid_in && ready_out;
    assign skip_status = (RUNNING_STATUS != 0) && last_valid && (last_status == status_q)
                         && (refresh_cnt < REFRESH_MAX);

    // DONE keeps ready_out high, so a waiting event can be captured there as well as in IDLE
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            ready_out    <= 1'b1;
            msg_done_out <= 1'b0;
            tx_trigger   <= 1'b0;
            tx_byte      <= 8'h00;
            status_q     <= 8'h00;
            note_q       <= 8'h00;
            vel_q        <= 8'h00;
            last_status  <= 8'h00;
            last_valid   <= 1'b0;
        end else begin
            tx_trigger   <= 1'b0;
            msg_done_out <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        status_q <= {status_in ? NOTE_ON : NOTE_OFF, channel_in};
                        note_q   <= note_in & 8'h7F;
                        vel_q    <= velocity_in & 8'h7F;
                        if ((note_in & 8'h7F) != 8'h00) begin
                            state     <= LOAD;
                            ready_out <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    tx_trigger <= 1'b1;
                    if (skip_status) begin
                        tx_byte <= note_q;
                        state   <= SEND_NOTE;
                    end else begin
                        tx_byte <= status_q;
                        state   <= SEND_STATUS;
                    end
                end
                SEND_STATUS: begin
                    if (tx_done && !tx_busy) begin
                        tx_trigger <= 1'b1;
                        tx_byte    <= note_q;
                        state      <= SEND_NOTE;
                    end
                end
                SEND_NOTE: begin
                    if (tx_done && !tx_busy) begin
                        tx_trigger <= 1'b1;
                        tx_byte    <= vel_q;
                        state      <= SEND_VEL;
                    end
                end
                SEND_VEL: begin
                    if (tx_done && !tx_busy) begin
                        state        <= DONE;
                        msg_done_out <= 1'b1;
                        ready_out    <= 1'b1;
                        last_status  <= status_q;
                        last_valid   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Age of the last transmitted status byte; saturates once running status has gone stale
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            refresh_cnt <= '0;
        end else if (state == LOAD && !skip_status) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt < REFRESH_MAX) begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    uart_transmit #(
        .INPUT_CLOCK_FREQ(INPUT_CLOCK_FREQ),
        .BAUD_RATE       (BAUD_RATE)
    ) u_tx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .trigger_in  (tx_trigger),
        .data_byte_in(tx_byte),
        .busy_out    (tx_busy),
        .done_out    (tx_done),
        .tx_wire_out (midi_data_out)
    );

endmodule

// File: tb/tb_midi_encode.sv
// Bench for midi_encode: two instances (plain and running status) on a scaled-down baud clock,
// with a line decoder per instance and an event-level reference model.
module tb_midi_encode;

    localparam int CLK_FREQ = 3200;
    localparam int BAUD     = 100;
    localparam int BP       = CLK_FREQ / BAUD;
    localparam int REFRESH  = 3000;

    typedef struct { logic [7:0] data; int start; logic bad; } rx_t;
    typedef struct { logic [7:0] data; logic first; } exp_t;
    typedef struct {
        logic on; logic [3:0] ch; logic [7:0] note; logic [7:0] vel;
        int nbytes; logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       st = 1'b0;
    logic [3:0] ch = 4'd0;
    logic [7:0] note = 8'd0, vel = 8'd0;
    logic       ready0, ready1, done0, done1, midi0, midi1;
    logic       prev_done0 = 1'b0, prev_done1 = 1'b0;

    int   nvec = 0;
    int   nmis = 0;
    int   cyc = 0;
    int   done_cnt[2] = '{0, 0};
    rx_t  rx_q0[$], rx_q1[$];
    exp_t exp_q0[$], exp_q1[$];
    logic [7:0] rs_last = 8'h00;
    logic       rs_valid = 1'b0;
    int         rs_time = 0;

    midi_encode #(.INPUT_CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .RUNNING_STATUS(0),
                  .STATUS_REFRESH_CYCLES(REFRESH)) dut0 (
        .clk_in(clk), .rst_in(rst), .data_valid_in(valid0), .status_in(st), .channel_in(ch),
        .note_in(note), .velocity_in(vel), .ready_out(ready0), .msg_done_out(done0),
        .midi_data_out(midi0));

    midi_encode #(.INPUT_CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .RUNNING_STATUS(1),
                  .STATUS_REFRESH_CYCLES(REFRESH)) dut1 (
        .clk_in(clk), .rst_in(rst), .data_valid_in(valid1), .status_in(st), .channel_in(ch),
        .note_in(note), .velocity_in(vel), .ready_out(ready1), .msg_done_out(done1),
        .midi_data_out(midi1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nvec++;
        if (actual !== expected) begin
            nmis++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // msg_done must be a single-cycle pulse coinciding with ready
    always @(negedge clk) begin
        if (done0) begin
            done_cnt[0]++;
            checkOutput("done0_ready", int'(ready0), 1);
            checkOutput("done0_width", int'(prev_done0), 0);
        end
        if (done1) begin
            done_cnt[1]++;
            checkOutput("done1_ready", int'(ready1), 1);
            checkOutput("done1_width", int'(prev_done1), 0);
        end
        prev_done0 = done0;
        prev_done1 = done1;
    end

    task automatic decodeLoop(input int d);
        logic [9:0] frame;
        logic       bad;
        logic       v;
        rx_t        r;
        forever begin
            @(negedge clk);
            if (!rst && ((d == 0) ? midi0 : midi1) === 1'b0) begin
                r.start = cyc;
                bad = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    if (b > 0) @(negedge clk);
                    v = (d == 0) ? midi0 : midi1;
                    for (int c = 1; c < BP; c++) begin
                        @(negedge clk);
                        if (((d == 0) ? midi0 : midi1) !== v || rst) bad = 1'b1;
                    end
                    frame[b] = v;
                end
                if (frame[0] !== 1'b0 || frame[9] !== 1'b1) bad = 1'b1;
                r.data = frame[8:1];
                r.bad  = bad;
                if (d == 0) rx_q0.push_back(r); else rx_q1.push_back(r);
            end
        end
    endtask

    initial decodeLoop(0);
    initial decodeLoop(1);

    task automatic pushExp(input int d, input logic [7:0] data, input logic first);
        exp_t e;
        e.data  = data;
        e.first = first;
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    endtask

    // Event-level model: which bytes a message puts on the line
    task automatic modelEvent(input int d, input logic on, input logic [3:0] c,
                              input logic [7:0] n, input logic [7:0] v);
        logic [7:0] s;
        logic       send_s;
        s = on ? (8'h90 | {4'h0, c}) : (8'h80 | {4'h0, c});
        if ((n & 8'h7F) == 8'h00) return;
        send_s = 1'b1;
        if (d == 1 && rs_valid && s == rs_last && (cyc - rs_time) < REFRESH) send_s = 1'b0;
        if (send_s) begin
            pushExp(d, s, 1'b1);
            if (d == 1) rs_time = cyc;
        end
        pushExp(d, n & 8'h7F, !send_s);
        pushExp(d, v & 8'h7F, 1'b0);
        if (d == 1) begin
            rs_last  = s;
            rs_valid = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int d, input logic on, input logic [3:0] c,
                                 input logic [7:0] n, input logic [7:0] v);
        int k = 0;
        @(negedge clk);
        while (((d == 0) ? ready0 : ready1) !== 1'b1 && k < 40 * BP) begin
            @(negedge clk);
            k++;
        end
        st = on; ch = c; note = n; vel = v;
        if (d == 0) valid0 = 1'b1; else valid1 = 1'b1;
        @(posedge clk);
        modelEvent(d, on, c, n, v);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic waitDone(input int d, input int target, input string name);
        int   k = 0;
        logic early_ready = 1'b0;
        while (k < 40 * BP) begin
            @(negedge clk);
            if (done_cnt[d] >= target) break;
            if (((d == 0) ? ready0 : ready1) === 1'b1 && ((d == 0) ? done0 : done1) !== 1'b1)
                early_ready = 1'b1;
            k++;
        end
        checkOutput({name, "_msg_done_count"}, done_cnt[d], target);
        checkOutput({name, "_ready_low"}, int'(early_ready), 0);
    endtask

    task automatic compareRx(input int d, input string name);
        rx_t  r;
        exp_t e;
        int   prev_start = 0;
        int   delta;
        checkOutput({name, "_nbytes"}, (d == 0) ? rx_q0.size() : rx_q1.size(),
                    (d == 0) ? exp_q0.size() : exp_q1.size());
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) > 0 &&
               ((d == 0) ? rx_q0.size() : rx_q1.size()) > 0) begin
            if (d == 0) begin r = rx_q0.pop_front(); e = exp_q0.pop_front(); end
            else        begin r = rx_q1.pop_front(); e = exp_q1.pop_front(); end
            checkOutput({name, "_byte"}, int'(r.data), int'(e.data));
            checkOutput({name, "_frame"}, int'(r.bad), 0);
            if (!e.first) begin
                delta = r.start - prev_start;
                checkOutput({name, "_gap_ok"}, (delta >= 10 * BP && delta <= 10 * BP + 2) ? 1 : 0, 1);
            end
            prev_start = r.start;
        end
        if (d == 0) begin rx_q0.delete(); exp_q0.delete(); end
        else        begin rx_q1.delete(); exp_q1.delete(); end
    endtask

    task automatic checkSilent(input int d, input int cycles, input string name);
        int   base = done_cnt[d];
        logic ready_ok = 1'b1;
        logic line_ok = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (((d == 0) ? ready0 : ready1) !== 1'b1) ready_ok = 1'b0;
            if (((d == 0) ? midi0 : midi1) !== 1'b1) line_ok = 1'b0;
        end
        checkOutput({name, "_no_done"}, done_cnt[d], base);
        checkOutput({name, "_ready_high"}, int'(ready_ok), 1);
        checkOutput({name, "_line_idle"}, int'(line_ok), 1);
        checkOutput({name, "_no_bytes"}, (d == 0) ? rx_q0.size() : rx_q1.size(), 0);
        if (d == 0) begin rx_q0.delete(); exp_q0.delete(); end
        else        begin rx_q1.delete(); exp_q1.delete(); end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[5];
        int         base;
        int         k;
        logic       on_r;
        logic [3:0] ch_r;
        logic [7:0] note_r, vel_r;

        vecs[0] = '{1'b1, 4'd3,  8'd60,  8'd100, 3, 8'h93, 8'h3C, 8'h64};
        vecs[1] = '{1'b0, 4'd0,  8'hBC,  8'h80,  3, 8'h80, 8'h3C, 8'h00};
        vecs[2] = '{1'b1, 4'd15, 8'h7F,  8'h7F,  3, 8'h9F, 8'h7F, 8'h7F};
        vecs[3] = '{1'b0, 4'd9,  8'h01,  8'hFF,  3, 8'h89, 8'h01, 8'h7F};
        vecs[4] = '{1'b1, 4'd5,  8'h80,  8'h40,  0, 8'h00, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        checkOutput("reset_line0", int'(midi0), 1);
        checkOutput("reset_ready0", int'(ready0), 1);
        checkOutput("reset_done0", int'(done0), 0);
        checkOutput("reset_line1", int'(midi1), 1);
        checkOutput("reset_ready1", int'(ready1), 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) begin
            base = done_cnt[0];
            applyStimulus(0, vecs[i].on, vecs[i].ch, vecs[i].note, vecs[i].vel);
            if (vecs[i].nbytes == 0) begin
                checkSilent(0, 3 * BP, "table_zero");
            end else begin
                waitDone(0, base + 1, "table");
                checkOutput("table_nbytes", rx_q0.size(), vecs[i].nbytes);
                if (rx_q0.size() == 3) begin
                    checkOutput("table_status", int'(rx_q0[0].data), int'(vecs[i].b0));
                    checkOutput("table_note", int'(rx_q0[1].data), int'(vecs[i].b1));
                    checkOutput("table_vel", int'(rx_q0[2].data), int'(vecs[i].b2));
                    for (int j = 0; j < 3; j++) checkOutput("table_frame", int'(rx_q0[j].bad), 0);
                end
                rx_q0.delete();
                exp_q0.delete();
            end
        end

        $display("[TB] capture-to-start latency");
        @(negedge clk);
        st = 1'b1; ch = 4'd3; note = 8'd60; vel = 8'd100; valid0 = 1'b1;
        base = done_cnt[0];
        @(posedge clk);
        modelEvent(0, 1'b1, 4'd3, 8'd60, 8'd100);
        #1 valid0 = 1'b0;
        @(negedge clk);
        checkOutput("lat_line_n", int'(midi0), 1);
        @(negedge clk);
        checkOutput("lat_line_n1", int'(midi0), 1);
        checkOutput("lat_ready_n1", int'(ready0), 0);
        @(negedge clk);
        checkOutput("lat_line_n2", int'(midi0), 0);
        waitDone(0, base + 1, "lat");
        compareRx(0, "lat");

        $display("[TB] event held valid during a message");
        base = done_cnt[0];
        @(negedge clk);
        st = 1'b1; ch = 4'd7; note = 8'd45; vel = 8'd20; valid0 = 1'b1;
        @(posedge clk);
        modelEvent(0, 1'b1, 4'd7, 8'd45, 8'd20);
        #1;
        st = 1'b0; ch = 4'd2; note = 8'd77; vel = 8'd99;
        k = 0;
        while (k < 40 * BP) begin
            @(negedge clk);
            k++;
            if (ready0 === 1'b1) begin
                @(posedge clk);
                modelEvent(0, 1'b0, 4'd2, 8'd77, 8'd99);
                #1;
                break;
            end
        end
        valid0 = 1'b0;
        waitDone(0, base + 2, "held");
        compareRx(0, "held");

        $display("[TB] note zero discarded");
        applyStimulus(0, 1'b1, 4'd4, 8'h00, 8'd64);
        checkSilent(0, 40 * BP, "zero");

        $display("[TB] random events");
        for (int i = 0; i < 8; i++) begin
            on_r   = 1'($urandom_range(0, 1));
            ch_r   = 4'($urandom_range(0, 15));
            note_r = 8'($urandom_range(0, 255));
            vel_r  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) note_r = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
            base = done_cnt[0];
            applyStimulus(0, on_r, ch_r, note_r, vel_r);
            if ((note_r & 8'h7F) == 8'h00) begin
                checkSilent(0, 3 * BP, "rand_zero");
            end else begin
                waitDone(0, base + 1, "rand");
                compareRx(0, "rand");
            end
        end

        $display("[TB] reset during velocity byte");
        applyStimulus(0, 1'b1, 4'd6, 8'd50, 8'h00);
        k = 0;
        while (rx_q0.size() < 2 && k < 40 * BP) begin
            @(negedge clk);
            k++;
        end
        repeat (4 * BP) @(negedge clk);
        checkOutput("pre_reset_line", int'(midi0), 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_mid_line", int'(midi0), 1);
        checkOutput("reset_mid_ready", int'(ready0), 1);
        checkOutput("reset_mid_done", int'(done0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rs_valid = 1'b0;
        repeat (12 * BP) @(negedge clk);
        rx_q0.delete();
        exp_q0.delete();
        base = done_cnt[0];
        applyStimulus(0, 1'b0, 4'd11, 8'd90, 8'd33);
        waitDone(0, base + 1, "after_reset");
        compareRx(0, "after_reset");

        $display("[TB] running status");
        base = done_cnt[1];
        applyStimulus(1, 1'b1, 4'd1, 8'd40, 8'd50);
        waitDone(1, base + 1, "rs_first");
        checkOutput("rs_first_len", rx_q1.size(), 3);
        compareRx(1, "rs_first");
        applyStimulus(1, 1'b1, 4'd1, 8'd41, 8'd51);
        waitDone(1, base + 2, "rs_second");
        checkOutput("rs_second_len", rx_q1.size(), 2);
        compareRx(1, "rs_second");
        applyStimulus(1, 1'b1, 4'd2, 8'd42, 8'd52);
        waitDone(1, base + 3, "rs_third");
        checkOutput("rs_third_len", rx_q1.size(), 3);
        compareRx(1, "rs_third");
        repeat (REFRESH + 1000) @(negedge clk);
        applyStimulus(1, 1'b1, 4'd2, 8'd43, 8'd53);
        waitDone(1, base + 4, "rs_stale");
        checkOutput("rs_stale_len", rx_q1.size(), 3);
        compareRx(1, "rs_stale");

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
